// File: rtl/sm_timer.sv
// sm_timer: memory-mapped down-counting timer with one-shot and auto-reload
// modes, write-1-to-clear expiry flag and a level interrupt.
//
// Optional feature macro: SM_TIMER_PRESCALER_EN
//   defined   - CTRL.PRESC divides the tick rate (tick every PRESC+1 cycles)
//   undefined - no prescaler, CTRL.PRESC reads 0, tick every running cycle
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bSel     - slave select from the bus matrix decoder
//   bAddr    - bus address, only [3:2] decoded
//   bWrite   - bus write enable
//   bWData   - bus write data
//   bRData   - combinational read data (valid regardless of bSel)
//   timerIrq - level interrupt, STATUS.EXP & CTRL.IE
//
// Register map (bAddr[3:2]):
//   0 CTRL   [0] EN, [1] AUTO, [2] IE, [8+PRESC_W-1:8] PRESC
//   1 PERIOD reload value
//   2 COUNT  current count
//   3 STATUS [0] EXP (write 1 to clear)
module sm_timer #(
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bSel,
    input  logic [31:0] bAddr,
    input  logic        bWrite,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    output logic        timerIrq
);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t      state;
    logic        auto_rl;
    logic        ie;
    logic [31:0] period;
    logic [31:0] count;
    logic        expired;

    logic        wr;
    logic        wr_ctrl;
    logic        wr_period;
    logic        wr_count;
    logic        wr_status;
    logic        tick;
    logic        expire;
    logic [31:0] ctrl_rd;

    assign wr        = bSel & bWrite;
    assign wr_ctrl   = wr && (bAddr[3:2] == 2'd0);
    assign wr_period = wr && (bAddr[3:2] == 2'd1);
    assign wr_count  = wr && (bAddr[3:2] == 2'd2);
    assign wr_status = wr && (bAddr[3:2] == 2'd3);

`ifdef SM_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;

    assign tick = (state == RUNNING) && (presc_cnt == presc);

    // Prescaler counter restarts on every CTRL write so a new divide ratio
    // always begins with a full PRESC+1 cycle interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else begin
            if (wr_ctrl) begin
                presc <= bWData[8 +: PRESC_W];
            end
            if (wr_ctrl || state == STOPPED || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[2:0]         = {ie, auto_rl, state == RUNNING};
        ctrl_rd[8 +: PRESC_W] = presc;
    end

    logic unused_bits;
    assign unused_bits = ^{bAddr[31:4], bAddr[1:0]};
`else
    assign tick = (state == RUNNING);

    always_comb begin
        ctrl_rd      = '0;
        ctrl_rd[2:0] = {ie, auto_rl, state == RUNNING};
    end

    logic [PRESC_W-1:0] unused_presc;
    logic               unused_bits;
    assign unused_presc = bWData[8 +: PRESC_W];
    assign unused_bits  = ^{bAddr[31:4], bAddr[1:0], unused_presc};
`endif

    assign expire = tick && (count == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STOPPED;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            period  <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            // A CTRL write decides the run state even when a one-shot
            // expiry lands on the same edge.
            if (wr_ctrl) begin
                state   <= bWData[0] ? RUNNING : STOPPED;
                auto_rl <= bWData[1];
                ie      <= bWData[2];
            end else if (expire && !auto_rl) begin
                state <= STOPPED;
            end

            if (wr_period) begin
                period <= bWData;
            end

            // Software COUNT writes beat the tick; enabling never reloads.
            if (wr_count) begin
                count <= bWData;
            end else if (tick) begin
                if (count != 32'd0) begin
                    count <= count - 32'd1;
                end else if (auto_rl) begin
                    count <= period;
                end
            end

            // Set has priority over a same-edge write-1-to-clear.
            expired <= expire | (expired & ~(wr_status & bWData[0]));
        end
    end

    always_comb begin
        case (bAddr[3:2])
            2'd0:    bRData = ctrl_rd;
            2'd1:    bRData = period;
            2'd2:    bRData = count;
            default: bRData = {31'd0, expired};
        endcase
    end

    assign timerIrq = expired & ie;

endmodule

// File: tb/tb_sm_timer.sv
module tb_sm_timer;

    localparam int PW = 8;

    logic        clk;
    logic        rst_n;
    logic        bSel;
    logic [31:0] bAddr;
    logic        bWrite;
    logic [31:0] bWData;
    logic [31:0] bRData;
    logic        timerIrq;

    sm_timer #(.PRESC_W(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bSel     (bSel),
        .bAddr    (bAddr),
        .bWrite   (bWrite),
        .bWData   (bWData),
        .bRData   (bRData),
        .timerIrq (timerIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of the register file
    bit          m_en;
    bit          m_auto;
    bit          m_ie;
    logic [31:0] m_presc;
    logic [31:0] m_period;
    logic [31:0] m_count;
    bit          m_exp;
    int          m_phase;   // running cycles elapsed in current prescale interval

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_presc = 0;
        m_period = 0; m_count = 0; m_exp = 0; m_phase = 0;
    endtask

    // Advance the model by one clock edge using the present bus inputs.
    task automatic model_step();
        bit          tick;
        bit          fire;
        bit          n_en;
        bit          n_exp;
        logic [31:0] n_count;
        int          n_phase;
        bit          wr;
        int          idx;
        wr  = bSel && bWrite;
        idx = int'(bAddr[3:2]);
`ifdef SM_TIMER_PRESCALER_EN
        tick = m_en && (m_phase == int'(m_presc));
`else
        tick = m_en;
`endif
        fire    = tick && (m_count == 0);
        n_en    = m_en;
        n_count = m_count;
        n_exp   = m_exp;
        if (tick) begin
            if (m_count != 0) n_count = m_count - 1;
            else if (m_auto) n_count = m_period;
            else n_en = 0;
        end
        if (!m_en || tick) n_phase = 0;
        else n_phase = m_phase + 1;
        if (wr && idx == 3 && bWData[0]) n_exp = 0;
        if (fire) n_exp = 1;
        if (wr && idx == 0) begin
            n_en    = bWData[0];
            m_auto  = bWData[1];
            m_ie    = bWData[2];
            n_phase = 0;
`ifdef SM_TIMER_PRESCALER_EN
            m_presc = (bWData >> 8) & ((32'd1 << PW) - 32'd1);
`endif
        end
        if (wr && idx == 1) m_period = bWData;
        if (wr && idx == 2) n_count = bWData;
        m_en    = n_en;
        m_count = n_count;
        m_exp   = n_exp;
        m_phase = n_phase;
    endtask

    function automatic logic [31:0] model_reg(input int idx);
        case (idx)
            0: return (m_presc << 8) | {29'd0, m_ie, m_auto, m_en};
            1: return m_period;
            2: return m_count;
            default: return {31'd0, m_exp};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bSel = 0; bWrite = 0;
        repeat (n) cycle();
    endtask

    task automatic bus_write(input int idx, input logic [31:0] data);
        bSel = 1; bWrite = 1; bAddr = 32'(idx) << 2; bWData = data;
        cycle();
        bSel = 0; bWrite = 0;
    endtask

    task automatic check_reg(input int idx, input logic [31:0] expv, input string tag);
        bSel = 0; bWrite = 0; bAddr = 32'(idx) << 2;
        #1;
        check(tag, bRData, expv);
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 4; i++) begin
            check_reg(i, model_reg(i), $sformatf("%s_reg%0d", tag, i));
        end
        check({tag, "_irq"}, {31'd0, timerIrq}, {31'd0, m_exp & m_ie});
    endtask

    int seq[6] = '{1, 0, 2, 1, 0, 2};

    initial begin
        logic [31:0] w;
        rst_n = 0; bSel = 0; bWrite = 0; bAddr = 0; bWData = 0;
        model_reset();
        #12 rst_n = 1;

        // Reset state
        for (int i = 0; i < 4; i++) check_reg(i, 32'd0, $sformatf("reset_reg%0d", i));
        check("reset_irq", {31'd0, timerIrq}, 32'd0);

        // Deselected write must not land
        bus_write(1, 32'h55);
        bSel = 0; bWrite = 1; bAddr = 32'h4; bWData = 32'hAA;
        cycle();
        bWrite = 0;
        check_reg(1, 32'h55, "nosel_period");
        check_model("map");

        // One-shot
        bus_write(2, 3);
        bus_write(0, 5);
        idle(3);
        check_reg(2, 0, "oneshot_cnt0");
        check_reg(3, 0, "oneshot_noexp");
        idle(1);
        check_reg(3, 1, "oneshot_exp");
        check("oneshot_irq", {31'd0, timerIrq}, 32'd1);
        check_reg(0, 32'h4, "oneshot_ctrl");
        idle(2);
        check_reg(2, 0, "oneshot_hold");
        check_model("oneshot");
        bus_write(3, 1);
        check("oneshot_clr_irq", {31'd0, timerIrq}, 32'd0);

        // Auto-reload, PERIOD=2
        bus_write(1, 2);
        bus_write(2, 2);
        bus_write(0, 3);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            check_reg(2, 32'(seq[k]), $sformatf("auto_cnt%0d", k));
            check_reg(3, (k >= 2) ? 32'd1 : 32'd0, $sformatf("auto_exp%0d", k));
        end
        check_model("auto");

        // Collisions
        bus_write(3, 1);
        check_reg(3, 0, "coll_clr");
        idle(1);
        check_reg(2, 0, "coll_pre");
        bus_write(3, 1);
        check_reg(3, 1, "coll_setwins");
        check_reg(2, 2, "coll_reload");
        bus_write(2, 7);
        check_reg(2, 7, "coll_cntwr");
        check_model("coll");

        // PERIOD=0 with AUTO expires on every tick
        bus_write(0, 0);
        bus_write(3, 1);
        bus_write(1, 0);
        bus_write(2, 0);
        bus_write(0, 3);
        idle(1);
        check_reg(3, 1, "p0_exp");
        check_reg(2, 0, "p0_cnt");
        bus_write(3, 1);
        check_reg(3, 1, "p0_setwins");
        check_model("p0");

        // Prescaler
        bus_write(0, 0);
        bus_write(3, 1);
        bus_write(2, 1);
        bus_write(0, 32'h301);
`ifdef SM_TIMER_PRESCALER_EN
        check_reg(0, 32'h301, "presc_ctrl");
        idle(7);
        check_reg(3, 0, "presc_early");
        idle(1);
        check_reg(3, 1, "presc_exp");
`else
        check_reg(0, 32'h1, "presc_ctrl");
        idle(1);
        check_reg(3, 0, "presc_early");
        idle(1);
        check_reg(3, 1, "presc_exp");
`endif
        check_model("presc");

        // Asynchronous reset mid-count
        bus_write(0, 0);
        bus_write(3, 1);
        bus_write(1, 9);
        bus_write(2, 5);
        bus_write(0, 5);
        idle(1);
        #2 rst_n = 0;
        for (int i = 0; i < 4; i++) check_reg(i, 32'd0, $sformatf("arst_reg%0d", i));
        check("arst_irq", {31'd0, timerIrq}, 32'd0);
        model_reset();
        rst_n = 1;
        idle(3);
        check_reg(2, 0, "arst_after_cnt");
        check_reg(3, 0, "arst_after_exp");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bSel   = ($urandom_range(0, 3) != 0);
            bWrite = ($urandom_range(0, 2) == 0);
            bAddr  = $urandom;
            w      = $urandom;
            if ($urandom_range(0, 3) != 0) w = w & 32'h0000_0307;
            bWData = w;
            cycle();
            check_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
